// File: rtl/ifb_pkg.sv
// Shared types for the instruction prefetch buffer: fetch FSM states, reset vector
// and the {pc, instr} entry stored in the FIFO.
package ifb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } ifb_state_e;

    localparam logic [31:0] IFB_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifb_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// Fetch-entry FIFO: DEPTH entries (power of two), flush, occupancy count with one extra
// bit so full and empty are distinguishable; pointers wrap naturally modulo DEPTH.
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  ifb_entry_t               i_data,
    input  logic                     i_pop,
    output ifb_entry_t               o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    ifb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_full;
    logic            w_push;
    logic            w_pop;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction fetcher with one outstanding imem request and a small FIFO.
// Optional IFB_BYPASS_EN: an ack into an empty FIFO is presented in the same cycle.
module instr_prefetch_buffer
    import ifb_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFB_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifb_state_e  r_state;
    ifb_state_e  w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_nxt;
    logic [31:0] r_drop_addr;
    logic        w_ack_accept;
    logic        w_bypass;
    logic        w_fifo_push;
    logic        w_fifo_pop;
    logic        w_fifo_empty;
    logic [CW-1:0] w_count;
    ifb_entry_t  w_ack_entry;
    ifb_entry_t  w_head;
    ifb_entry_t  w_out;
    ifb_entry_t  r_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            // Keep the orphaned request's address on the bus until its ack arrives.
            if (r_state == ST_REQ && w_state_nxt == ST_DROP)
                r_drop_addr <= r_fetch_pc;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_ack_accept   = 1'b0;
        imem_req       = (r_state != ST_IDLE);
        imem_addr      = (r_state == ST_DROP) ? r_drop_addr : r_fetch_pc;
        case (r_state)
            ST_IDLE: begin
                if (redirect)
                    w_fetch_pc_nxt = redirect_pc;
                else if (w_count < CW'(DEPTH))
                    w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                    w_state_nxt    = imem_ack ? ST_IDLE : ST_DROP;
                end else if (imem_ack) begin
                    w_ack_accept   = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect) w_fetch_pc_nxt = redirect_pc;
                if (imem_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ack_entry = {r_fetch_pc, imem_rdata};

`ifdef IFB_BYPASS_EN
    assign w_bypass = w_ack_accept && w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_fifo_push = w_ack_accept && !(w_bypass && instr_ready);
    assign w_fifo_pop  = !w_fifo_empty && instr_ready && !redirect;

    ifb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_flush (redirect),
        .i_push  (w_fifo_push),
        .i_data  (w_ack_entry),
        .i_pop   (w_fifo_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_fifo_empty)
    );

    // With nothing to show, the head outputs keep the last value presented.
    assign w_out       = w_bypass ? w_ack_entry : (w_fifo_empty ? r_last : w_head);
    assign instr_valid = !w_fifo_empty || w_bypass;
    assign instr       = w_out.instr;
    assign instr_pc    = w_out.pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_last <= '0;
        else if (instr_valid)
            r_last <= w_out;
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Bench for instr_prefetch_buffer: an imem responder with programmable latency and a
// program-order reference (expected pc stream + occupancy) checking every cycle.
module tb_instr_prefetch_buffer;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;
`ifdef IFB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // imem responder
    bit          pend;
    bit          poison;
    int          lat;
    int          lat_mode;
    logic [31:0] req_addr;
    bit          saw_new_req;
    logic [31:0] new_req_addr;

    // reference model
    int          occ;
    logic [31:0] exp_pc;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    int          n_pops;
    int          n_acks;
    int          last_pop_cyc;
    bit          chk_spacing;
    bit          seen_zero;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        occ        = 0;
        exp_pc     = RST_PC;
        last_pc    = '0;
        last_instr = '0;
        pend       = 1'b0;
        poison     = 1'b0;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        imem_ack = 1'b0;
        redirect = 1'b0;
        #1;
        chk("rst_imem_req",    32'(imem_req), 0);
        chk("rst_imem_addr",   imem_addr, RST_PC);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instr",       instr, 0);
        chk("rst_instr_pc",    instr_pc, 0);
        reset_model();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock cycle, entered and left 1 time unit after the rising edge.
    task automatic tick(input bit redir, input logic [31:0] rpc, input bit rdy);
        bit ack, byp, exp_valid, pop, push;
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        if (imem_req && !pend) begin
            pend         = 1'b1;
            poison       = 1'b0;
            req_addr     = imem_addr;
            lat          = (lat_mode < 0) ? int'($urandom_range(3)) : lat_mode;
            saw_new_req  = 1'b1;
            new_req_addr = imem_addr;
        end else if (pend) begin
            if (imem_req) chk("addr_stable", imem_addr, req_addr);
            else pend = 1'b0;
        end
        if (pend && redir) poison = 1'b1;
        ack = pend && (lat == 0);
        if (pend && lat > 0) lat--;
        imem_ack   = ack;
        imem_rdata = ack ? (poison ? POISON : hash(req_addr)) : $urandom;
        #1;
        byp       = BYP && ack && !poison && (occ == 0);
        exp_valid = (occ != 0) || byp;
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("head_pc",    instr_pc, exp_pc);
            chk("head_instr", instr, hash(exp_pc));
            last_pc    = exp_pc;
            last_instr = hash(exp_pc);
        end else begin
            chk("hold_pc",    instr_pc, last_pc);
            chk("hold_instr", instr, last_instr);
        end
        pop = exp_valid && rdy && !redir;
        if (pop) begin
            if (chk_spacing && n_pops > 0) chk("pop_spacing", cyc - last_pop_cyc, 2);
            last_pop_cyc = cyc;
            n_pops++;
            if (exp_pc == 32'h0) seen_zero = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
        push = ack && !poison && !(byp && rdy);
        if (ack && !poison) n_acks++;
        if (redir) begin
            occ    = 0;
            exp_pc = rpc;
        end else begin
            occ = occ + int'(push) - int'(pop);
        end
        if (ack) pend = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_new_req(input int budget, input bit rdy);
        int k;
        k = 0;
        while (!saw_new_req && k < budget) begin
            tick(1'b0, 32'h0, rdy);
            k++;
        end
        chk("req_timeout", 32'(saw_new_req), 1);
    endtask

    initial begin
        int k;
        reset_n = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        lat_mode = 0; chk_spacing = 1'b0; n_pops = 0; n_acks = 0;
        last_pop_cyc = 0; seen_zero = 1'b0; saw_new_req = 1'b0; new_req_addr = '0;
        req_addr = '0; lat = 0;
        reset_model();
        #1;
        do_reset();

        // 1: back-to-back fetch, ack with zero added latency, consumer always ready
        lat_mode = 0; chk_spacing = 1'b1; n_pops = 0;
        repeat (40) tick(1'b0, 32'h0, 1'b1);
        chk_spacing = 1'b0;
        chk("t1_pops", n_pops, 20);

        // 2: consumer stalled fills the FIFO, then drains and fetching resumes
        do_reset();
        n_acks = 0;
        repeat (20) tick(1'b0, 32'h0, 1'b0);
        chk("t2_acks", n_acks, DEPTH);
        chk("t2_req_idle", 32'(imem_req), 0);
        n_pops = 0; saw_new_req = 1'b0;
        repeat (DEPTH) tick(1'b0, 32'h0, 1'b1);
        chk("t2_drained", n_pops, DEPTH);
        wait_new_req(10, 1'b1);
        chk("t2_resume_addr", new_req_addr, 32'h0040_0010);

        // 3: redirect while a slow request is pending; its data must be discarded
        lat_mode = 3; k = 0;
        while (!(imem_req && !pend) && k < 20) begin
            tick(1'b0, 32'h0, 1'b1);
            k++;
        end
        tick(1'b1, 32'h0040_0100, 1'b1);
        saw_new_req = 1'b0;
        wait_new_req(20, 1'b1);
        chk("t3_new_addr", new_req_addr, 32'h0040_0100);
        repeat (20) tick(1'b0, 32'h0, 1'b1);

        // 4: redirect coinciding with an ack and a pop at two buffered entries
        lat_mode = 0;
        tick(1'b1, 32'h0040_0200, 1'b0);
        k = 0;
        while (occ < 2 && k < 20) begin
            tick(1'b0, 32'h0, 1'b0);
            k++;
        end
        chk("t4_occ", occ, 2);
        tick(1'b0, 32'h0, 1'b0);
        chk("t4_req_before", 32'(imem_req), 1);
        tick(1'b1, 32'h0040_0300, 1'b1);
        chk("t4_valid_after", 32'(instr_valid), 0);
        tick(1'b0, 32'h0, 1'b1);
        chk("t4_req_after", 32'(imem_req), 1);
        chk("t4_addr_after", imem_addr, 32'h0040_0300);
        repeat (10) tick(1'b0, 32'h0, 1'b1);

        // 5: address wrap through the top of the address space
        tick(1'b1, 32'hFFFF_FFF8, 1'b1);
        seen_zero = 1'b0;
        repeat (12) tick(1'b0, 32'h0, 1'b1);
        chk("t5_wrap_seen", 32'(seen_zero), 1);

        // 6: asynchronous reset while a request is outstanding
        lat_mode = 3; k = 0;
        while (!(imem_req && !pend) && k < 20) begin
            tick(1'b0, 32'h0, 1'b1);
            k++;
        end
        chk("t6_req_pending", 32'(imem_req), 1);
        do_reset();
        saw_new_req = 1'b0;
        wait_new_req(10, 1'b1);
        chk("t6_first_addr", new_req_addr, RST_PC);

        // randomized traffic: redirects, stalls and variable latency
        lat_mode = -1; n_pops = 0;
        for (int i = 0; i < 500; i++) begin
            logic [31:0] r;
            r = $urandom;
            r[1:0] = 2'b00;
            tick(($urandom_range(19) == 0), r, ($urandom_range(9) < 7));
        end
        chk("rand_progress", 32'(n_pops > 30), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
